// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, CONFIG_R bit positions and the UART data address.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam int CFG_EN = 0;
  localparam int CFG_PAR_EN = 1;
  localparam int CFG_PAR_ODD = 2;
  localparam int CFG_STOP2 = 3;
  localparam logic [31:0] UART_DATA_ADDR = 32'h70;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: pipeline-side register/strobe bundle and serial status of the UART transmitter.
interface uart_tx_if;
  logic new_data;
  logic [31:0] DATA_R, CONFIG_R, BAUD_DIV;
  logic tx, busy, tx_done, overrun;
  modport master (output new_data, DATA_R, CONFIG_R, BAUD_DIV, input tx, busy, tx_done, overrun);
  modport slave (input new_data, DATA_R, CONFIG_R, BAUD_DIV, output tx, busy, tx_done, overrun);
endinterface

// File: rtl/uart_tx_baud_gen.sv
// baud_gen: reloadable down-counter; bit_tick marks the last clock of each bit period.
module baud_gen #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [CNT_W-1:0] div,
  output logic             bit_tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign bit_tick = cnt_q == '0;
  always_comb cnt_d = (restart || bit_tick) ? div - CNT_W'(1) : cnt_q - CNT_W'(1);
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8E1/8O1/8N2 serial transmitter with a one-entry holding buffer and sticky overrun.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int DATA_BITS = 8
) (
  input logic      clk,
  input logic      reset,
  uart_tx_if.slave bus
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  state_e state_q;
  logic tx_q, buf_v_q, ovr_q, par_en_q, par_q, stop2_q, stop_q;
  logic [DATA_BITS-1:0] sh_q, buf_q, in_byte, nxt_byte;
  logic [BW-1:0] bit_q;
  logic [CNT_W-1:0] div_q, eff_div;
  logic acc, tick, frame_end, start, unused_bits;
  assign in_byte = bus.DATA_R[DATA_BITS-1:0];
  assign unused_bits = ^{bus.DATA_R[31:DATA_BITS], bus.CONFIG_R[31:4]};
  assign acc = bus.new_data & bus.CONFIG_R[CFG_EN];
  assign eff_div = bus.BAUD_DIV[CNT_W-1:0] == '0 ? CNT_W'(1) : bus.BAUD_DIV[CNT_W-1:0];
  assign frame_end = state_q == STOP && tick && (!stop2_q || stop_q);
  // the buffered byte always wins a start slot; a fresh byte then takes its place
  assign start = (acc || buf_v_q) && (state_q == IDLE || frame_end);
  assign nxt_byte = buf_v_q ? buf_q : in_byte;
  assign bus.tx = tx_q;
  assign bus.busy = state_q != IDLE || buf_v_q;
  assign bus.tx_done = frame_end;
  assign bus.overrun = ovr_q;
  baud_gen #(.CNT_W(CNT_W)) u_baud (
    .clk,
    .reset,
    .restart (start),
    .div     (start ? eff_div : div_q),
    .bit_tick(tick)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q <= 1'b1;
      buf_v_q <= 1'b0;
      buf_q <= '0;
      ovr_q <= 1'b0;
      sh_q <= '0;
      bit_q <= '0;
      div_q <= '0;
      par_en_q <= 1'b0;
      par_q <= 1'b0;
      stop2_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      buf_v_q <= start ? acc && buf_v_q : buf_v_q || acc;
      if (acc && start == buf_v_q) buf_q <= in_byte;
      if (acc && !start && buf_v_q) ovr_q <= 1'b1;
      if (start) begin
        state_q <= START;
        tx_q <= 1'b0;
        sh_q <= nxt_byte;
        div_q <= eff_div;
        par_en_q <= bus.CONFIG_R[CFG_PAR_EN];
        par_q <= ^nxt_byte ^ bus.CONFIG_R[CFG_PAR_ODD];
        stop2_q <= bus.CONFIG_R[CFG_STOP2];
      end else if (tick) begin
        case (state_q)
          START: begin
            state_q <= DATA;
            tx_q <= sh_q[0];
            sh_q <= sh_q >> 1;
            bit_q <= '0;
          end
          DATA: if (bit_q == LAST) begin
            state_q <= par_en_q ? PARITY : STOP;
            tx_q <= par_en_q ? par_q : 1'b1;
            stop_q <= 1'b0;
          end else begin
            tx_q <= sh_q[0];
            sh_q <= sh_q >> 1;
            bit_q <= bit_q + BW'(1);
          end
          PARITY: begin
            state_q <= STOP;
            tx_q <= 1'b1;
            stop_q <= 1'b0;
          end
          STOP: if (frame_end) begin
            state_q <= IDLE;
            tx_q <= 1'b1;
          end else stop_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frames pushed to a scoreboard; a negedge monitor checks tx cycle by cycle.
module tb_uart_tx;
  typedef struct {
    logic [7:0] d;
    bit par_en;
    bit par_v;
    int periods;
    int div;
    int start_cyc;
  } item_t;
  logic clk = 0, rst = 1;
  int cyc = 0, n_chk = 0, n_pass = 0;
  bit act = 0, after = 0;
  item_t sb[$];
  uart_tx_if bus();
  uart_tx dut (.clk(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
  endtask
  task automatic send(logic [7:0] d);
    bus.DATA_R = {24'hABCDE0, d};
    bus.new_data = 1;
    @(posedge clk); #1;
    bus.new_data = 0;
  endtask
  task automatic push(logic [7:0] d, bit pe, bit pv, int periods, int div, int sc);
    item_t it;
    it.d = d; it.par_en = pe; it.par_v = pv; it.periods = periods; it.div = div; it.start_cyc = sc;
    sb.push_back(it);
  endtask
  task automatic wait_done(int budget);
    int n = 0;
    while ((sb.size() != 0 || act || after) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_timeout", n < budget, 1);
  endtask
  // monitor: pops an expected frame at each start bit and compares every clock of it
  initial begin : mon
    item_t it;
    logic w[$];
    logic b;
    int i, last_end;
    i = 0; last_end = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 0; after = 0;
        continue;
      end
      if (after) begin
        after = 0;
        if (sb.size() == 0) begin
          chk("busy_fall", bus.busy, 0);
          chk("tx_idle", bus.tx, 1);
        end
      end
      if (!act) begin
        if (bus.tx === 1'b0 && sb.size() != 0) begin
          it = sb.pop_front();
          w.delete();
          for (int p = 0; p < it.periods; p++) begin
            b = p == 0 ? 1'b0 : p <= 8 ? it.d[p-1] : (p == 9 && it.par_en) ? it.par_v : 1'b1;
            repeat (it.div) w.push_back(b);
          end
          if (it.start_cyc >= 0) chk("start_latency", cyc, it.start_cyc);
          else chk("b2b_gap", cyc, last_end + 1);
          act = 1; i = 0;
        end else begin
          chk("stray_start_tx", bus.tx, 1);
          chk("idle_tx_done", bus.tx_done, 0);
        end
      end
      if (act) begin
        chk("tx_bit", bus.tx, w[i]);
        chk("tx_done", bus.tx_done, i == w.size() - 1);
        chk("busy_frame", bus.busy, 1);
        i++;
        if (i == w.size()) begin
          act = 0; after = 1; last_end = cyc;
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int s;
    bus.new_data = 0; bus.DATA_R = 0; bus.CONFIG_R = 0; bus.BAUD_DIV = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_done", bus.tx_done, 0);
    chk("rst_overrun", bus.overrun, 0);
    rst = 0;
    // 8N1 at 4 clocks/bit; later config changes must not disturb the frame in flight
    bus.CONFIG_R = 1; bus.BAUD_DIV = 4;
    push(8'h55, 0, 0, 10, 4, cyc + 1);
    send(8'h55);
    bus.CONFIG_R = 32'hF; bus.BAUD_DIV = 7;
    wait_done(100);
    chk("t1_overrun", bus.overrun, 0);
    // even then odd parity on 0x07
    bus.CONFIG_R = 3; bus.BAUD_DIV = 2;
    push(8'h07, 1, 1, 11, 2, cyc + 1);
    send(8'h07);
    wait_done(100);
    bus.CONFIG_R = 7;
    push(8'h07, 1, 0, 11, 2, cyc + 1);
    send(8'h07);
    wait_done(100);
    // back-to-back through the buffer, third byte dropped
    bus.CONFIG_R = 1; bus.BAUD_DIV = 2;
    push(8'hA5, 0, 0, 10, 2, cyc + 1);
    send(8'hA5);
    @(posedge clk); #1;
    push(8'h3C, 0, 0, 10, 2, -1);
    send(8'h3C);
    send(8'hFF);
    chk("ovr_set", bus.overrun, 1);
    chk("ovr_busy", bus.busy, 1);
    wait_done(200);
    chk("ovr_sticky", bus.overrun, 1);
    // divider 0 acts as 1, two stop bits
    bus.CONFIG_R = 9; bus.BAUD_DIV = 0;
    push(8'h80, 0, 0, 11, 1, cyc + 1);
    send(8'h80);
    wait_done(100);
    // reset in the middle of data bit 3
    bus.CONFIG_R = 1; bus.BAUD_DIV = 4;
    s = cyc + 1;
    push(8'h55, 0, 0, 10, 4, s);
    send(8'h55);
    for (int k = 0; k < 100 && cyc < s + 17; k++) begin
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_tx", bus.tx, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_overrun", bus.overrun, 0);
    sb.delete();
    push(8'h3C, 0, 0, 10, 4, cyc + 1);
    send(8'h3C);
    wait_done(100);
    // disabled transmitter ignores the strobe
    bus.CONFIG_R = 0;
    send(8'h5A);
    for (int k = 0; k < 6; k++) begin
      chk("dis_tx", bus.tx, 1);
      chk("dis_busy", bus.busy, 0);
      chk("dis_overrun", bus.overrun, 0);
      @(posedge clk); #1;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
